// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and redirect-kind encoding for the fetch stage
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_INC = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;
    typedef enum logic {
        ABS = 1'b0,
        REL = 1'b1
    } redirect_kind_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO with push/pop/flush and full/empty flags
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign dout = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencer feeding an instruction queue, with redirects.
// Optional perf counters (perf_fetched, perf_stall) when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               start_up,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic               redirect_rel,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic [ADDR_W-1:0]  redirect_base,
    input  logic [15:0]        redirect_imm16
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC) & ~ADDR_W'(3);
    logic [ADDR_W-1:0] fpc, rel_off, raw_target, target;
    logic full, empty, pop, redirect;
    logic [INSTR_W+ADDR_W-1:0] head;
    assign redirect = redirect_valid && !start_up;
    assign pop = out_valid && out_ready;
    assign imem_en = !start_up && !redirect_valid && (!full || pop);
    assign imem_addr = fpc;
    assign out_valid = !empty;
    assign out_instr = head[ADDR_W +: INSTR_W];
    assign out_pc = head[ADDR_W-1:0];
    // Word offset sign-extends before the ADDR_W-bit wrapping add.
    always_comb begin
        rel_off = ADDR_W'($signed({redirect_imm16, 2'b00}));
        raw_target = (redirect_kind_e'(redirect_rel) == REL)
            ? redirect_base + ADDR_W'(PC_INC) + rel_off : redirect_target;
        target = raw_target & ~ADDR_W'(3);
    end
    always_ff @(posedge clk) begin
        if (start_up) fpc <= RST_PC;
        else if (redirect) fpc <= target;
        else if (imem_en) fpc <= fpc + ADDR_W'(PC_INC);
    end
    fetch_queue #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_queue (
        .clk(clk),
        .rst(start_up),
        .push(imem_en),
        .pop(pop),
        .flush(redirect),
        .din({imem_rdata, fpc}),
        .dout(head),
        .full(full),
        .empty(empty)
    );
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (start_up) begin
            perf_fetched <= '0;
            perf_stall <= '0;
        end else begin
            if (imem_en && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (!redirect_valid && !imem_en && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`else
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic clk = 0;
    logic start_up = 1;
    logic imem_en, out_valid, out_ready = 1;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
    logic redirect_valid = 0, redirect_rel = 0;
    logic [31:0] redirect_target = 0, redirect_base = 0;
    logic [15:0] redirect_imm16 = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr;

    fetch_stage dut (
        .clk(clk),
        .start_up(start_up),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .redirect_valid(redirect_valid),
        .redirect_rel(redirect_rel),
        .redirect_target(redirect_target),
        .redirect_base(redirect_base),
        .redirect_imm16(redirect_imm16)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_abs(input logic [31:0] t);
        redirect_valid = 1;
        redirect_rel = 0;
        redirect_target = t;
        tick();
        redirect_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tick();
        tick();
        #1;
        check("rst_en", imem_en, 0);
        check("rst_valid", out_valid, 0);
        start_up = 0;
        #1;
        check("first_en", imem_en, 1);
        check("first_addr", imem_addr, 32'h0040_0020);
        tick();
        #1;
        check("seq_addr1", imem_addr, 32'h0040_0024);
        check("lat_valid", out_valid, 1);
        check("lat_pc", out_pc, 32'h0040_0020);
        check("lat_instr", out_instr, 32'h0040_0020);
        tick();
        #1;
        check("seq_addr2", imem_addr, 32'h0040_0028);
        check("seq_pc2", out_pc, 32'h0040_0024);

        start_up = 1;
        out_ready = 0;
        tick();
        start_up = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_en) n++;
            tick();
        end
        #1;
        check("full_pushes", n, 4);
        check("full_en", imem_en, 0);
        check("full_hold", imem_addr, 32'h0040_0030);
        check("full_head", out_pc, 32'h0040_0020);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 4);
        check("perf_stall", perf_stall, 4);
`endif
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("drain_valid", out_valid, 1);
            check("drain_pc", out_pc, 32'h0040_0020 + 4 * k);
            tick();
        end

        redirect_valid = 1;
        redirect_rel = 1;
        redirect_base = 32'h0040_0100;
        redirect_imm16 = 16'hFFFF;
        #1;
        check("redir_en", imem_en, 0);
        tick();
        redirect_valid = 0;
        #1;
        check("rel_addr", imem_addr, 32'h0040_0100);
        check("rel_flush", out_valid, 0);
        tick();
        #1;
        check("rel_pc", out_pc, 32'h0040_0100);

        out_ready = 0;
        for (int i = 0; i < 6; i++) tick();
        #1;
        check("fill_en", imem_en, 0);
        out_ready = 1;
        redirect_abs(32'h0000_1003);
        #1;
        check("abs_addr", imem_addr, 32'h0000_1000);
        check("abs_flush", out_valid, 0);

        redirect_abs(32'hFFFF_FFF8);
        #1;
        check("wrap_f8", imem_addr, 32'hFFFF_FFF8);
        tick();
        #1;
        check("wrap_fc", imem_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        check("wrap_zero", imem_addr, 32'h0000_0000);
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);

        out_ready = 0;
        redirect_abs(32'h0000_0200);
        tick();
        tick();
        tick();
        #1;
        check("three_valid", out_valid, 1);
        check("three_addr", imem_addr, 32'h0000_020C);
        start_up = 1;
        redirect_valid = 1;
        redirect_target = 32'h0000_8000;
        out_ready = 1;
        #1;
        check("su_en", imem_en, 0);
        tick();
        start_up = 0;
        redirect_valid = 0;
        #1;
        check("su_valid", out_valid, 0);
        check("su_addr", imem_addr, 32'h0040_0020);
`ifdef FETCH_PERF_EN
        check("su_perf_f", perf_fetched, 0);
        check("su_perf_s", perf_stall, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
